// File: rtl/enet_pkg.sv
// Shared definitions for the Ethernet transmit arbiter: FSM encoding, port count,
// stream payload layout and the round-robin pick helper.
package enet_pkg;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned STRB_W    = 4;
  localparam int unsigned PAYLOAD_W = DATA_W + STRB_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // One-hot winner; on a tie the port that was not served last wins.
  function automatic logic [NUM_PORTS-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                   input logic last_port);
    logic [NUM_PORTS-1:0] win;
    if (req == 2'b11) begin
      win = last_port ? 2'b01 : 2'b10;
    end else begin
      win = req;
    end
    return win;
  endfunction

endpackage

// File: rtl/enet_skid_buf.sv
// Two-entry registered FIFO between the arbiter mux and the MAC write port;
// head_q drives the output directly, skid_q absorbs one beat of backpressure.
module enet_skid_buf
  import enet_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 in_valid_i,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  input  logic                 out_accept_i
);

  logic [1:0]           count_q, count_d;
  logic [PAYLOAD_W-1:0] head_q, head_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 push;
  logic                 pop;

  assign in_ready_o    = (count_q != 2'd2);
  assign out_valid_o   = (count_q != 2'd0);
  assign out_payload_o = head_q;
  assign push          = in_valid_i && in_ready_o;
  assign pop           = out_valid_o && out_accept_i;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = in_payload_i;
        end else begin
          skid_d = in_payload_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_d = skid_q;
        end else begin
          head_d = head_q;
        end
        count_d = count_q - 2'd1;
      end
      // Push while popping only happens at count 1: new beat replaces the head.
      2'b11: begin
        head_d = in_payload_i;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= 2'd0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/enet_tx_arb.sv
// Frame-atomic round-robin arbiter for two transmit sources feeding the MAC.
// Optional per-port frame counters are built when ENET_TX_ARB_STATS_EN is defined.
module enet_tx_arb
  import enet_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        busy_i,
  input  logic        in0_valid_i,
  input  logic [31:0] in0_data_i,
  input  logic [3:0]  in0_strb_i,
  input  logic        in0_last_i,
  output logic        in0_accept_o,
  input  logic        in1_valid_i,
  input  logic [31:0] in1_data_i,
  input  logic [3:0]  in1_strb_i,
  input  logic        in1_last_i,
  output logic        in1_accept_o,
  output logic        tx_valid_o,
  output logic [31:0] tx_data_o,
  output logic [3:0]  tx_strb_o,
  output logic        tx_last_o,
  input  logic        tx_accept_i,
  output logic [1:0]  grant_o,
  output logic [15:0] frames0_o,
  output logic [15:0] frames1_o
);

  localparam logic [7:0] GAP_LOAD = (IDLE_GAP > 0) ? 8'(IDLE_GAP - 1) : 8'd0;

  state_t               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_q, last_d;
  logic [7:0]           gap_q, gap_d;
  logic [1:0]           pick;
  logic                 sel_valid;
  logic [PAYLOAD_W-1:0] sel_payload;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 buf_ready;
  logic                 push;

  always_comb begin
    sel_valid   = 1'b0;
    sel_payload = '0;
    if (grant_q[0]) begin
      sel_valid   = in0_valid_i;
      sel_payload = {in0_data_i, in0_strb_i, in0_last_i};
    end else if (grant_q[1]) begin
      sel_valid   = in1_valid_i;
      sel_payload = {in1_data_i, in1_strb_i, in1_last_i};
    end else begin
      sel_valid   = 1'b0;
      sel_payload = '0;
    end
  end

  assign in0_accept_o = grant_q[0] && buf_ready;
  assign in1_accept_o = grant_q[1] && buf_ready;
  assign push         = sel_valid && buf_ready;
  assign pick         = rr_pick({in1_valid_i, in0_valid_i}, last_q);
  assign grant_o      = grant_q;

  enet_skid_buf u_skid (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .in_valid_i   (sel_valid),
    .in_payload_i (sel_payload),
    .in_ready_o   (buf_ready),
    .out_valid_o  (tx_valid_o),
    .out_payload_o(out_payload),
    .out_accept_i (tx_accept_i)
  );

  assign {tx_data_o, tx_strb_o, tx_last_o} = out_payload;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (!busy_i && (pick != 2'b00)) begin
          grant_d = pick;
          last_d  = pick[1];
          state_d = pick[0] ? ST_GRANT0 : ST_GRANT1;
        end else begin
          grant_d = 2'b00;
        end
      end
      // busy_i is deliberately ignored here so a started frame always completes.
      ST_GRANT0, ST_GRANT1: begin
        if (push && sel_payload[0]) begin
          grant_d = 2'b00;
          if (IDLE_GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          grant_d = grant_q;
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      gap_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

`ifdef ENET_TX_ARB_STATS_EN
  logic [15:0] frames0_q, frames0_d;
  logic [15:0] frames1_q, frames1_d;

  always_comb begin
    frames0_d = frames0_q;
    frames1_d = frames1_q;
    if (in0_valid_i && in0_accept_o && in0_last_i) begin
      frames0_d = frames0_q + 16'd1;
    end else begin
      frames0_d = frames0_q;
    end
    if (in1_valid_i && in1_accept_o && in1_last_i) begin
      frames1_d = frames1_q + 16'd1;
    end else begin
      frames1_d = frames1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frames0_q <= 16'd0;
      frames1_q <= 16'd0;
    end else begin
      frames0_q <= frames0_d;
      frames1_q <= frames1_d;
    end
  end

  assign frames0_o = frames0_q;
  assign frames1_o = frames1_q;
`else
  assign frames0_o = 16'd0;
  assign frames1_o = 16'd0;
`endif

endmodule

// File: tb/tb_enet_tx_arb.sv
// Directed bench for enet_tx_arb: one instance with IDLE_GAP=0 and one with
// IDLE_GAP=4 share the same stimulus.
module tb_enet_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy = 1'b0;
  logic        tx_accept = 1'b1;
  logic        in0_valid = 1'b0, in1_valid = 1'b0;
  logic        in0_last = 1'b0, in1_last = 1'b0;
  logic [31:0] in0_data = 32'd0, in1_data = 32'd0;
  logic [3:0]  in0_strb = 4'hF, in1_strb = 4'hF;

  logic        in0_acc, in1_acc, tx_valid, tx_last;
  logic [31:0] tx_data;
  logic [3:0]  tx_strb;
  logic [1:0]  grant;
  logic [15:0] fr0, fr1;

  logic        g_in0_acc, g_in1_acc, g_tx_valid, g_tx_last;
  logic [31:0] g_tx_data;
  logic [3:0]  g_tx_strb;
  logic [1:0]  g_grant;
  logic [15:0] g_fr0, g_fr1;

  int checks = 0;
  int failures = 0;
  int b0, b1, f0, f1, nout, done;
  logic fire0, fire1;
  logic [31:0] rr_exp [8] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0100, 32'hA000_0101,
                              32'hA000_0010, 32'hA000_0011, 32'hA000_0110, 32'hA000_0111};

  always #5 clk = ~clk;

  enet_tx_arb #(.IDLE_GAP(0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .busy_i(busy),
    .in0_valid_i(in0_valid), .in0_data_i(in0_data), .in0_strb_i(in0_strb),
    .in0_last_i(in0_last), .in0_accept_o(in0_acc),
    .in1_valid_i(in1_valid), .in1_data_i(in1_data), .in1_strb_i(in1_strb),
    .in1_last_i(in1_last), .in1_accept_o(in1_acc),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_strb_o(tx_strb),
    .tx_last_o(tx_last), .tx_accept_i(tx_accept),
    .grant_o(grant), .frames0_o(fr0), .frames1_o(fr1)
  );

  enet_tx_arb #(.IDLE_GAP(4)) dg (
    .clk_i(clk), .rst_n_i(rst_n), .busy_i(busy),
    .in0_valid_i(in0_valid), .in0_data_i(in0_data), .in0_strb_i(in0_strb),
    .in0_last_i(in0_last), .in0_accept_o(g_in0_acc),
    .in1_valid_i(in1_valid), .in1_data_i(in1_data), .in1_strb_i(in1_strb),
    .in1_last_i(in1_last), .in1_accept_o(g_in1_acc),
    .tx_valid_o(g_tx_valid), .tx_data_o(g_tx_data), .tx_strb_o(g_tx_strb),
    .tx_last_o(g_tx_last), .tx_accept_i(tx_accept),
    .grant_o(g_grant), .frames0_o(g_fr0), .frames1_o(g_fr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; busy = 1'b0; tx_accept = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b0; in0_last = 1'b0; in1_last = 1'b0;
    in0_strb = 4'hF; in1_strb = 4'hF; in0_data = 32'd0; in1_data = 32'd0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state of both instances
    #2;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_tx_strb_last", {27'd0, tx_strb, tx_last}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_accepts", {30'd0, in1_acc, in0_acc}, 32'd0);
    chk("rst_frames", {fr1, fr0}, 32'd0);
    chk("rst_g_grant_valid", {29'd0, g_grant, g_tx_valid}, 32'd0);

    // Single 3-beat frame on port 0
    do_reset();
    in0_valid = 1'b1; in0_data = 32'h1111_1111; in0_last = 1'b0;
    chk("t1_grant_N", {30'd0, grant}, 32'd0);
    step();
    chk("t1_grant_N1", {30'd0, grant}, 32'd1);
    chk("t1_accept_N1", {31'd0, in0_acc}, 32'd1);
    chk("t1_txvalid_N1", {31'd0, tx_valid}, 32'd0);
    step();
    chk("t1_txvalid_N2", {31'd0, tx_valid}, 32'd1);
    chk("t1_data_N2", tx_data, 32'h1111_1111);
    in0_data = 32'h2222_2222;
    step();
    chk("t1_data_N3", tx_data, 32'h2222_2222);
    chk("t1_grant_N3", {30'd0, grant}, 32'd1);
    in0_data = 32'h3333_3333; in0_last = 1'b1; in0_strb = 4'h3;
    step();
    chk("t1_data_N4", tx_data, 32'h3333_3333);
    chk("t1_last_N4", {31'd0, tx_last}, 32'd1);
    chk("t1_strb_N4", {28'd0, tx_strb}, 32'd3);
    chk("t1_grant_N4", {30'd0, grant}, 32'd0);
    in0_valid = 1'b0; in0_last = 1'b0; in0_strb = 4'hF;
    step();
    chk("t1_txvalid_N5", {31'd0, tx_valid}, 32'd0);

    // Both ports stream 2-beat frames, IDLE_GAP = 0
    do_reset();
    b0 = 0; b1 = 0; f0 = 0; f1 = 0; nout = 0; done = 0;
    in0_valid = 1'b1; in1_valid = 1'b1;
    in0_data = 32'hA000_0000; in1_data = 32'hA000_0100;
    for (int c = 0; c < 14; c++) begin
      if (c % 3 == 1) chk("rr_grant", {30'd0, grant}, (c % 6 == 1) ? 32'd1 : 32'd2);
      if (c % 3 == 0 && c > 0) chk("rr_gap_grant", {30'd0, grant}, 32'd0);
      if (tx_valid && tx_accept) begin
        if (nout < 8) chk("rr_beat", tx_data, rr_exp[nout]);
        else chk("rr_extra_beat", nout, 32'd8);
        nout++;
      end
      fire0 = in0_valid && in0_acc;
      fire1 = in1_valid && in1_acc;
      if (c < 12 && ((fire0 && in0_last) || (fire1 && in1_last))) done++;
      step();
      if (fire0) begin
        if (b0 == 1) begin b0 = 0; f0++; end else b0 = 1;
      end
      if (fire1) begin
        if (b1 == 1) begin b1 = 0; f1++; end else b1 = 1;
      end
      in0_data = 32'hA000_0000 + 32'(f0 * 16 + b0); in0_last = (b0 == 1);
      in1_data = 32'hA000_0100 + 32'(f1 * 16 + b1); in1_last = (b1 == 1);
    end
    chk("rr_frames_in_12", done, 32'd4);
    chk("rr_beats_out", nout, 32'd8);

    // busy_i holds off grants but never interrupts a frame
    do_reset();
    busy = 1'b1; in1_valid = 1'b1; in1_data = 32'hC000_0000; in1_last = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("busy_hold", {30'd0, grant}, 32'd0);
      step();
    end
    busy = 1'b0;
    step();
    chk("busy_release_grant", {30'd0, grant}, 32'd2);
    chk("busy_release_acc", {31'd0, in1_acc}, 32'd1);
    busy = 1'b1;
    step();
    chk("busy_midframe_grant", {30'd0, grant}, 32'd2);
    in1_data = 32'hC000_0001;
    step();
    in1_data = 32'hC000_0002; in1_last = 1'b1;
    step();
    chk("busy_frame_done_grant", {30'd0, grant}, 32'd0);
    chk("busy_frame_done_data", tx_data, 32'hC000_0002);
    chk("busy_frame_done_last", {31'd0, tx_last}, 32'd1);
    in1_valid = 1'b0; in1_last = 1'b0; in0_valid = 1'b1;
    step();
    chk("busy_blocks_next", {30'd0, grant}, 32'd0);

    // Backpressure: tx_accept low for 5 cycles during a 6-beat frame
    do_reset();
    b0 = 0; nout = 0;
    in0_valid = 1'b1; in0_data = 32'hB000_0000; in0_last = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tx_accept = !(c >= 1 && c <= 5);
      if (c == 2) chk("bp_acc_open", {31'd0, in0_acc}, 32'd1);
      if (c == 3) chk("bp_acc_full", {31'd0, in0_acc}, 32'd0);
      if (c == 5) chk("bp_hold_data", tx_data, 32'hB000_0000);
      if (tx_valid && tx_accept) begin
        chk("bp_beat", tx_data, 32'hB000_0000 + 32'(nout));
        chk("bp_last", {31'd0, tx_last}, (nout == 5) ? 32'd1 : 32'd0);
        nout++;
      end
      fire0 = in0_valid && in0_acc;
      step();
      if (fire0) begin
        b0++;
        in0_data = 32'hB000_0000 + 32'(b0);
        in0_last = (b0 == 5);
        if (b0 == 6) in0_valid = 1'b0;
      end
    end
    chk("bp_beats_out", nout, 32'd6);
    tx_accept = 1'b1;

    // IDLE_GAP = 4: port 1 waits 4 idle cycles after port 0's last beat
    do_reset();
    in0_valid = 1'b1; in0_last = 1'b1; in0_data = 32'hD000_0000;
    in1_valid = 1'b1; in1_last = 1'b1; in1_data = 32'hE000_0000;
    step();
    chk("gap_grant0", {30'd0, g_grant}, 32'd1);
    step();
    in0_valid = 1'b0;
    for (int c = 2; c < 7; c++) begin
      chk("gap_idle", {30'd0, g_grant}, 32'd0);
      step();
    end
    chk("gap_grant1", {30'd0, g_grant}, 32'd2);
    step();
    in1_valid = 1'b0;
    step();
`ifdef ENET_TX_ARB_STATS_EN
    chk("stats_frames0", {16'd0, g_fr0}, 32'd1);
    chk("stats_frames1", {16'd0, g_fr1}, 32'd1);
    force dg.frames0_q = 16'hFFFF;
    #1;
    release dg.frames0_q;
    chk("stats_preset", {16'd0, g_fr0}, 32'h0000_FFFF);
    in0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fire0 = in0_valid && g_in0_acc;
      step();
      if (fire0) in0_valid = 1'b0;
    end
    chk("stats_wrap", {16'd0, g_fr0}, 32'd0);
`else
    chk("stats_off_frames0", {16'd0, g_fr0}, 32'd0);
    chk("stats_off_frames1", {16'd0, g_fr1}, 32'd0);
`endif

    // Async reset mid-frame, then first tie goes to port 0
    do_reset();
    in0_valid = 1'b1; in0_last = 1'b0; in0_data = 32'h0000_F00D;
    step();
    step();
    chk("rstmid_pre_data", tx_data, 32'h0000_F00D);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rstmid_tx_data", tx_data, 32'd0);
    chk("rstmid_grant", {30'd0, grant}, 32'd0);
    chk("rstmid_accept", {31'd0, in0_acc}, 32'd0);
    in1_valid = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("rstmid_tie_port0", {30'd0, grant}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
